// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between instruction and data requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data has fixed priority.
module sram_like_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [DATA_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic              grant_any;
  logic              grant_data;
  logic              buf_wr;
  logic [1:0]        buf_size;
  logic [DATA_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              owner_data;

  assign grant_any = inst_req | data_req;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = inst, 1 = data; a tie goes to whoever was not granted last
  logic last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= 1'b0;
    else if (state == IDLE && grant_any)
      last_grant <= grant_data;
  end

  assign grant_data = data_req & (~inst_req | ~last_grant);
`else
  assign grant_data = data_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt    = REQ;
          data_addr_ok = grant_data;
          inst_addr_ok = ~grant_data;
        end
      end
      REQ: begin
        if (mem_addr_ok)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_data_ok) begin
          state_nxt    = IDLE;
          inst_data_ok = ~owner_data;
          data_data_ok = owner_data;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
    end
  end

  // Request buffer: captured only at accept, so later requester activity cannot disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_wr     <= 1'b0;
      buf_size   <= 2'd0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      owner_data <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      buf_wr     <= grant_data ? data_wr    : inst_wr;
      buf_size   <= grant_data ? data_size  : inst_size;
      buf_addr   <= grant_data ? data_addr  : inst_addr;
      buf_wdata  <= grant_data ? data_wdata : inst_wdata;
      owner_data <= grant_data;
    end
  end

  assign mem_req    = (state == REQ);
  assign mem_wr     = buf_wr;
  assign mem_size   = buf_size;
  assign mem_addr   = buf_addr;
  assign mem_wdata  = buf_wdata;
  assign busy       = (state != IDLE);
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule
